// File: rtl/comp2_accum.sv
// Signed burst accumulator: sums N_SAMPLES sign-extended 4-bit samples into an
// ACC_W-bit register, with a one-cycle completion strobe and sticky overflow.
module comp2_accum #(
  parameter int unsigned N_SAMPLES = 4,
  parameter int unsigned ACC_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             din_valid,
  input  logic [3:0]       din,
  output logic             din_ready,
  output logic             busy,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(N_SAMPLES + 1);
  localparam int unsigned EXT_W = ACC_W - 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               din_ready_q, busy_q, sum_valid_q;

  logic [ACC_W-1:0]   din_ext;
  logic [ACC_W-1:0]   add_res;
  logic               add_ovf;

  // Overflow when both operands share a sign and the wrapped result does not.
  always_comb begin
    din_ext = {{EXT_W{din[3]}}, din};
    add_res = acc_q + din_ext;
    add_ovf = (acc_q[ACC_W-1] == din[3]) && (add_res[ACC_W-1] != din[3]);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACC;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_ACC: begin
        if (din_valid) begin
          acc_d = add_res;
          cnt_d = cnt_q + CNT_W'(1);
          if (add_ovf) begin
            ovf_d = 1'b1;
          end
          if (cnt_q == CNT_W'(N_SAMPLES - 1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      din_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      din_ready_q <= (state_d == S_ACC);
      busy_q      <= (state_d != S_IDLE);
      sum_valid_q <= (state_d == S_DONE);
    end
  end

  assign din_ready = din_ready_q;
  assign busy      = busy_q;
  assign sum_valid = sum_valid_q;
  assign sum       = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_comp2_accum.sv
// Bench for comp2_accum: two instances (4-sample and 20-sample bursts) share
// stimulus and are checked every cycle against an integer-arithmetic model.
module tb_comp2_accum;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       din_valid;
  logic [3:0] din;

  logic       rdy0, busy0, sv0, ovf0;
  logic [7:0] sum0;
  logic       rdy1, busy1, sv1, ovf1;
  logic [7:0] sum1;

  int checks = 0;
  int errors = 0;

  // Model: phase 0=idle 1=accumulating 2=done; acc is the signed value held.
  int m_phase[2];
  int m_acc[2];
  int m_cnt[2];
  int m_ovf[2];
  int n_of[2] = '{4, 20};
  int sv_cnt[2];

  comp2_accum #(.N_SAMPLES(4), .ACC_W(8)) dut0 (
    .clk(clk), .reset(reset), .start(start), .din_valid(din_valid), .din(din),
    .din_ready(rdy0), .busy(busy0), .sum(sum0), .sum_valid(sv0), .ovf(ovf0)
  );

  comp2_accum #(.N_SAMPLES(20), .ACC_W(8)) dut1 (
    .clk(clk), .reset(reset), .start(start), .din_valid(din_valid), .din(din),
    .din_ready(rdy1), .busy(busy1), .sum(sum1), .sum_valid(sv1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0;
      m_acc[i]   = 0;
      m_cnt[i]   = 0;
      m_ovf[i]   = 0;
    end
  endfunction

  function automatic void model_edge();
    int s;
    int v;
    s = int'($signed(din));
    for (int i = 0; i < 2; i++) begin
      case (m_phase[i])
        0: if (start) begin
             m_phase[i] = 1; m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
           end
        1: if (din_valid) begin
             v = m_acc[i] + s;
             if (v > 127 || v < -128) m_ovf[i] = 1;
             if (v > 127) v -= 256;
             if (v < -128) v += 256;
             m_acc[i] = v;
             m_cnt[i]++;
             if (m_cnt[i] == n_of[i]) m_phase[i] = 2;
           end
        default: m_phase[i] = 0;
      endcase
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ":rdy0"},  32'(rdy0),  32'(m_phase[0] == 1));
    chk({tag, ":busy0"}, 32'(busy0), 32'(m_phase[0] != 0));
    chk({tag, ":sv0"},   32'(sv0),   32'(m_phase[0] == 2));
    chk({tag, ":sum0"},  32'(sum0),  32'(m_acc[0] & 255));
    chk({tag, ":ovf0"},  32'(ovf0),  32'(m_ovf[0]));
    chk({tag, ":rdy1"},  32'(rdy1),  32'(m_phase[1] == 1));
    chk({tag, ":busy1"}, 32'(busy1), 32'(m_phase[1] != 0));
    chk({tag, ":sv1"},   32'(sv1),   32'(m_phase[1] == 2));
    chk({tag, ":sum1"},  32'(sum1),  32'(m_acc[1] & 255));
    chk({tag, ":ovf1"},  32'(ovf1),  32'(m_ovf[1]));
  endtask

  // Apply inputs for one cycle, advance the model at the edge, check after it.
  task automatic step(input logic st, input logic dv, input logic [3:0] d);
    start = st; din_valid = dv; din = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all("cyc");
    if (sv0) sv_cnt[0]++;
    if (sv1) sv_cnt[1]++;
  endtask

  // Reset asserted mid-cycle must clear the outputs without waiting for a clock.
  task automatic reset_pulse();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; din_valid = 1'b0; din = 4'd0;
    model_reset();
    #12;
    check_all("por");
    @(negedge clk);
    reset = 1'b0;

    // Basic burst -1, +2, -8, +7
    sv_cnt = '{0, 0};
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'hF); chk("t1_s1", 32'(sum0), 32'h0FF);
    step(1'b0, 1'b1, 4'h2); chk("t1_s2", 32'(sum0), 32'h001);
    step(1'b0, 1'b1, 4'h8); chk("t1_s3", 32'(sum0), 32'h0F9);
    step(1'b0, 1'b1, 4'h7); chk("t1_s4", 32'(sum0), 32'h000);
    chk("t1_sv", 32'(sv0), 32'd1);
    chk("t1_ovf", 32'(ovf0), 32'd0);
    step(1'b0, 1'b0, 4'h0); chk("t1_idle", 32'(busy0), 32'd0);
    step(1'b0, 1'b0, 4'h0);
    chk("t1_svcnt", 32'(sv_cnt[0]), 32'd1);

    // Stalled burst of +7 x4
    sv_cnt = '{0, 0};
    step(1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 4'h7);
      if (k < 3) begin
        step(1'b0, 1'b0, 4'h3);
        step(1'b0, 1'b0, 4'h3);
      end
    end
    chk("t2_sum", 32'(sum0), 32'h01C);
    chk("t2_sv", 32'(sv0), 32'd1);
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    chk("t2_svcnt", 32'(sv_cnt[0]), 32'd1);

    // Overflow on the 20-sample instance
    reset_pulse();
    step(1'b1, 1'b0, 4'h0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b1, 4'h8);
      if (k == 16) chk("t3_ovf16", 32'(ovf1), 32'd0);
      if (k == 17) begin
        chk("t3_sum17", 32'(sum1), 32'h078);
        chk("t3_ovf17", 32'(ovf1), 32'd1);
      end
    end
    chk("t3_sum", 32'(sum1), 32'h060);
    chk("t3_ovf", 32'(ovf1), 32'd1);
    chk("t3_sv", 32'(sv1), 32'd1);
    step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h0);
    chk("t3_ovfclr", 32'(ovf1), 32'd0);

    // Ignored inputs: din_valid in IDLE, start in ACC and DONE
    reset_pulse();
    step(1'b0, 1'b1, 4'h5);
    step(1'b0, 1'b1, 4'h5);
    chk("t4_idle_sum", 32'(sum0), 32'd0);
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h1);
    step(1'b1, 1'b1, 4'h1);
    step(1'b0, 1'b1, 4'h1);
    step(1'b0, 1'b1, 4'h1);
    chk("t4_sum", 32'(sum0), 32'd4);
    chk("t4_sv", 32'(sv0), 32'd1);
    step(1'b1, 1'b0, 4'h0);
    chk("t4_done_start", 32'(busy0), 32'd0);

    // Reset mid-burst, then a fresh +1 x4 burst
    reset_pulse();
    sv_cnt = '{0, 0};
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h3);
    step(1'b0, 1'b1, 4'h3);
    reset_pulse();
    chk("t5_sum_rst", 32'(sum0), 32'd0);
    step(1'b0, 1'b0, 4'h0);
    chk("t5_nosv", 32'(sv_cnt[0]), 32'd0);
    step(1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 4'h1);
    chk("t5_sum", 32'(sum0), 32'd4);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      if (k % 151 == 150) reset_pulse();
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
